// File: rtl/vram_arbiter.sv
// Arbitrates one synchronous single-port memory (1-cycle read latency) between the
// CPU bus and the video fetcher. Video has fixed priority; a starvation counter
// forces a CPU grant after STARVE_LIMIT consecutive video grants while the CPU waits.
// One access is in flight at a time: IDLE (grant) -> ISSUE -> RESP -> IDLE.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // CPU requester
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  // Video requester (read only)
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  // Memory port
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_cpu_q, owner_cpu_d;
  logic                op_we_q, op_we_d;
  logic [CntW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;

  logic cpu_elig, vid_elig, starve_full;
  logic grant_cpu, grant_vid;

  // A request seen in the same cycle as its own ack is the stale tail of the
  // completed access, not a new one.
  assign cpu_elig    = cpu_req_i & ~cpu_ack_q;
  assign vid_elig    = vid_req_i & ~vid_ack_q;
  assign starve_full = (starve_q == CntW'(STARVE_LIMIT));

  // Next-state: grant decision, access sequencing and response capture
  always_comb begin
    state_d     = state_q;
    owner_cpu_d = owner_cpu_q;
    op_we_d     = op_we_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    grant_cpu   = 1'b0;
    grant_vid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_cpu = cpu_elig & (~vid_elig | starve_full);
        grant_vid = vid_elig & ~grant_cpu;

        if (!cpu_req_i || grant_cpu) begin
          starve_d = '0;
        end else if (grant_vid && !starve_full) begin
          starve_d = starve_q + CntW'(1);
        end

        if (grant_cpu) begin
          owner_cpu_d = 1'b1;
          op_we_d     = cpu_we_i;
          mem_addr_d  = cpu_addr_i;
          mem_we_d    = cpu_we_i;
          mem_wdata_d = cpu_wdata_i;
          state_d     = StIssue;
        end else if (grant_vid) begin
          owner_cpu_d = 1'b0;
          op_we_d     = 1'b0;
          mem_addr_d  = vid_addr_i;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        // Memory samples this cycle; keep write strobe to a single cycle
        mem_we_d = 1'b0;
        state_d  = StResp;
      end

      StResp: begin
        if (owner_cpu_q) begin
          cpu_ack_d = 1'b1;
          if (!op_we_q) begin
            cpu_rdata_d = mem_rdata_i;
          end
        end else begin
          vid_ack_d   = 1'b1;
          vid_rdata_d = mem_rdata_i;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      owner_cpu_q <= 1'b0;
      op_we_q     <= 1'b0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_cpu_q <= owner_cpu_d;
      op_we_q     <= op_we_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign vid_ack_o   = vid_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign vid_rdata_o = vid_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter #(
    .ADDR_W      (24),
    .DATA_W      (8),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_rdata_o(cpu_rdata),
    .vid_req_i  (vid_req),
    .vid_addr_i (vid_addr),
    .vid_ack_o  (vid_ack),
    .vid_rdata_o(vid_rdata),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, 16 locations selected by the low address nibble
  logic [7:0] mem [16];
  logic       mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[3:0]];
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [16];
  int          m_ph = 0;       // cycles since grant: 0 idle, 1 issue, 2 response
  int          m_starve = 0;
  bit          m_cpu, m_we;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata, m_rd;
  logic        e_cpu_ack = 0, e_vid_ack = 0, e_mem_we = 0;
  logic [7:0]  e_cpu_rdata = 0, e_vid_rdata = 0, e_mem_wdata = 0;
  logic [23:0] e_mem_addr = 0;

  // Advance the model by one clock using the inputs applied this cycle
  task automatic model_step();
    bit ce, ve, gc, gv;
    if (m_ph == 1 && m_we) ref_mem[m_addr[3:0]] = m_wdata;
    if (reset) begin
      e_cpu_ack = 0; e_vid_ack = 0; e_cpu_rdata = 0; e_vid_rdata = 0;
      e_mem_addr = 0; e_mem_we = 0; e_mem_wdata = 0;
      m_ph = 0; m_starve = 0;
      return;
    end
    ce = cpu_req && !e_cpu_ack;
    ve = vid_req && !e_vid_ack;
    e_cpu_ack = 0;
    e_vid_ack = 0;
    if (m_ph == 0) begin
      gc = ce && (!ve || m_starve == LIMIT);
      gv = ve && !gc;
      if (!cpu_req || gc) m_starve = 0;
      else if (gv && m_starve < LIMIT) m_starve++;
      if (gc || gv) begin
        m_cpu   = gc;
        m_we    = gc && cpu_we;
        m_addr  = gc ? cpu_addr : vid_addr;
        m_wdata = gc ? cpu_wdata : 8'h00;
        e_mem_addr  = m_addr;
        e_mem_we    = m_we;
        e_mem_wdata = m_wdata;
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      m_rd     = ref_mem[m_addr[3:0]];
      e_mem_we = 0;
      m_ph     = 2;
    end else begin
      if (m_cpu) begin
        e_cpu_ack = 1;
        if (!m_we) e_cpu_rdata = m_rd;
      end else begin
        e_vid_ack   = 1;
        e_vid_rdata = m_rd;
      end
      m_ph = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
    chk("vid_ack", 32'(vid_ack), 32'(e_vid_ack));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    chk("vid_rdata", 32'(vid_rdata), 32'(e_vid_rdata));
    chk("mem_we", 32'(mem_we), 32'(e_mem_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    if (e_mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
  endtask

  // One clock: predict, advance, sample 1 time unit after the edge, compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- randomized requesters ----------------
  bit cpu_done = 0, vid_done = 0;

  // Requests are held until ack (including the ack cycle), then optionally renewed
  task automatic drive_random(input int cpu_rate, input int vid_rate);
    if (cpu_ack) begin
      cpu_done = 1;
    end else begin
      if (cpu_done || !cpu_req) begin
        cpu_req   = ($urandom_range(0, 99) < cpu_rate);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 24'($urandom);
        cpu_wdata = 8'($urandom);
      end
      cpu_done = 0;
    end
    if (vid_ack) begin
      vid_done = 1;
    end else begin
      if (vid_done || !vid_req) begin
        vid_req  = ($urandom_range(0, 99) < vid_rate);
        vid_addr = 24'($urandom);
      end
      vid_done = 0;
    end
  endtask

  task automatic run_random(input int cycles, input int cpu_rate, input int vid_rate,
                            input bit with_reset);
    for (int n = 0; n < cycles; n++) begin
      if (with_reset && $urandom_range(0, 199) == 0) begin
        reset = 1; cpu_req = 0; vid_req = 0; cpu_done = 0; vid_done = 0;
      end else begin
        reset = 0;
        drive_random(cpu_rate, vid_rate);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 5);
    mem_load = 1;
    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; vid_addr = 0;

    // 1: reset with both requests high
    reset = 1; cpu_req = 1; vid_req = 1;
    tick();
    tick();
    reset = 0; cpu_req = 0; vid_req = 0; mem_load = 0;
    tick();
    tick();

    // 2: CPU write then read back
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h001234; cpu_wdata = 8'hA5;
    tick(); chk("t2_we_t1", 32'(mem_we), 32'd1);
    tick(); chk("t2_we_t2", 32'(mem_we), 32'd0);
    tick(); chk("t2_wr_ack_t3", 32'(cpu_ack), 32'd1);
    tick(); cpu_we = 0;
    tick();
    tick();
    tick(); chk("t2_rd_ack_t3", 32'(cpu_ack), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'hA5);
    tick(); cpu_req = 0;
    tick();

    // 3: simultaneous requests, video first
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h00ABC4;
    vid_req = 1; vid_addr = 24'h000007;
    tick();
    tick();
    tick(); chk("t3_vid_ack_t3", 32'(vid_ack), 32'd1);
    chk("t3_cpu_wait", 32'(cpu_ack), 32'd0);
    tick(); vid_req = 0;
    tick();
    tick(); chk("t3_cpu_ack_t6", 32'(cpu_ack), 32'd1);
    chk("t3_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    tick(); cpu_req = 0;
    tick();

    // 4: both requesters saturated
    cpu_done = 0; vid_done = 0;
    run_random(60, 100, 100, 0);
    run_random(10, 0, 0, 0);

    // 5: reset while a CPU read is in ISSUE
    cpu_req = 0; vid_req = 0;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000003;
    tick();
    reset = 1; cpu_req = 0;
    tick(); chk("t5_reset_mem_addr", 32'(mem_addr), 32'd0);
    reset = 0; vid_req = 1; vid_addr = 24'h000002;
    tick();
    tick();
    tick(); chk("t5_vid_ack", 32'(vid_ack), 32'd1);
    chk("t5_no_cpu_ack", 32'(cpu_ack), 32'd0);
    tick(); vid_req = 0;
    tick();
    cpu_done = 0; vid_done = 0;

    // 6: video streaming alone
    run_random(80, 0, 100, 0);
    run_random(60, 0, 50, 0);
    run_random(10, 0, 0, 0);

    // Randomized mixed traffic with occasional resets
    run_random(400, 30, 30, 1);
    run_random(400, 70, 50, 1);
    run_random(400, 90, 90, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
